// File: rtl/hardwired_control_unit.sv
// Hardwired control unit: owns the T1..T4 step sequence, latches a one-hot
// opcode and register selects on Start, and drives the register, Y, ALU and
// Z control lines. Mul/Div stall in T2 until AluDone, with a bounded wait.
module hardwired_control_unit #(
  parameter int unsigned NREG     = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Ins,
  input  logic [SEL_W-1:0] SrcA,
  input  logic [SEL_W-1:0] SrcB,
  input  logic [SEL_W-1:0] Dst,
  input  logic             AluDone,
  output logic             Run,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic             Yin,
  output logic             SelectY,
  output logic             Zin,
  output logic             Zout,
  output logic             Add,
  output logic             Sub,
  output logic             Mul,
  output logic             Div,
  output logic             End,
  output logic             Error,
  output logic [4:0]       Step
);

  // One extra bit so NREG == 2^SEL_W still compares correctly.
  localparam logic [SEL_W:0] NREG_LIM = (SEL_W+1)'(NREG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4
  } state_t;

  state_t            state_q;
  state_t            nxt_state;
  logic [3:0]        ins_q;
  logic [3:0]        nxt_ins;
  logic [SEL_W-1:0]  srca_q;
  logic [SEL_W-1:0]  srcb_q;
  logic [SEL_W-1:0]  dst_q;
  logic [SEL_W-1:0]  nxt_srca;
  logic [SEL_W-1:0]  nxt_srcb;
  logic [SEL_W-1:0]  nxt_dst;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] nxt_wait;
  logic              nxt_err;
  logic              req_ok;
  logic              multi_q;
  logic              nxt_multi;
  logic              zin_q;

  // A request is acceptable only with a one-hot opcode and in-range selects.
  assign req_ok = $onehot(Ins)
                  && ({1'b0, SrcA} < NREG_LIM)
                  && ({1'b0, SrcB} < NREG_LIM)
                  && ({1'b0, Dst}  < NREG_LIM);

  assign multi_q   = ins_q[2] | ins_q[3];
  assign nxt_multi = nxt_ins[2] | nxt_ins[3];

  // Zin for Mul/Div follows AluDone live in T2; Add/Sub use the registered strobe.
  assign Zin = zin_q | ((state_q == S_T2) & multi_q & AluDone);

  // Next-state, field latching, wait counter and error decision.
  always_comb begin
    nxt_state = state_q;
    nxt_ins   = ins_q;
    nxt_srca  = srca_q;
    nxt_srcb  = srcb_q;
    nxt_dst   = dst_q;
    nxt_wait  = wait_q;
    nxt_err   = 1'b0;
    case (state_q)
      S_IDLE, S_T4: begin
        nxt_state = S_IDLE;
        if (Start) begin
          if (req_ok) begin
            nxt_state = S_T1;
            nxt_ins   = Ins;
            nxt_srca  = SrcA;
            nxt_srcb  = SrcB;
            nxt_dst   = Dst;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      S_T1: nxt_state = S_T2;
      S_T2: begin
        if (!multi_q) begin
          nxt_state = S_T3;
        end else if (AluDone) begin
          nxt_state = S_T3;
          nxt_wait  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          nxt_state = S_IDLE;
          nxt_err   = 1'b1;
          nxt_wait  = '0;
        end else begin
          nxt_wait = wait_q + WAIT_W'(1);
        end
      end
      S_T3: nxt_state = S_T4;
      default: nxt_state = S_IDLE;
    endcase
  end

  // State/field registers and outputs registered from the upcoming state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ins_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      dst_q   <= '0;
      wait_q  <= '0;
      Run     <= 1'b0;
      Rin     <= '0;
      Rout    <= '0;
      Yin     <= 1'b0;
      SelectY <= 1'b0;
      zin_q   <= 1'b0;
      Zout    <= 1'b0;
      Add     <= 1'b0;
      Sub     <= 1'b0;
      Mul     <= 1'b0;
      Div     <= 1'b0;
      End     <= 1'b0;
      Error   <= 1'b0;
      Step    <= 5'b00001;
    end else begin
      state_q <= nxt_state;
      ins_q   <= nxt_ins;
      srca_q  <= nxt_srca;
      srcb_q  <= nxt_srcb;
      dst_q   <= nxt_dst;
      wait_q  <= nxt_wait;
      Error   <= nxt_err;
      Run     <= (nxt_state != S_IDLE);
      Rin     <= '0;
      Rout    <= '0;
      Yin     <= 1'b0;
      SelectY <= 1'b0;
      zin_q   <= 1'b0;
      Zout    <= 1'b0;
      Add     <= 1'b0;
      Sub     <= 1'b0;
      Mul     <= 1'b0;
      Div     <= 1'b0;
      End     <= 1'b0;
      case (nxt_state)
        S_T1: begin
          Step <= 5'b00010;
          Rout <= NREG'(1) << nxt_srca;
          Yin  <= 1'b1;
        end
        S_T2: begin
          Step    <= 5'b00100;
          Rout    <= NREG'(1) << nxt_srcb;
          SelectY <= 1'b1;
          Add     <= nxt_ins[0];
          Sub     <= nxt_ins[1];
          Mul     <= nxt_ins[2];
          Div     <= nxt_ins[3];
          zin_q   <= !nxt_multi;
        end
        S_T3: begin
          Step <= 5'b01000;
          Zout <= 1'b1;
          Rin  <= NREG'(1) << nxt_dst;
        end
        S_T4: begin
          Step <= 5'b10000;
          End  <= 1'b1;
        end
        default: Step <= 5'b00001;
      endcase
    end
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Self-checking bench for hardwired_control_unit: directed scenarios plus a
// randomized instruction stream checked against a latency-based model.
module tb_hardwired_control_unit;

  localparam int NREG     = 4;
  localparam int SEL_W    = 3;
  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = 4;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [3:0]       Ins;
  logic [SEL_W-1:0] SrcA;
  logic [SEL_W-1:0] SrcB;
  logic [SEL_W-1:0] Dst;
  logic             AluDone;
  logic             Run;
  logic [NREG-1:0]  Rin;
  logic [NREG-1:0]  Rout;
  logic             Yin;
  logic             SelectY;
  logic             Zin;
  logic             Zout;
  logic             Add;
  logic             Sub;
  logic             Mul;
  logic             Div;
  logic             End;
  logic             Error;
  logic [4:0]       Step;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  int          ph_q[$];
  bit          done_q[$];
  logic [23:0] obs;

  hardwired_control_unit #(
    .NREG(NREG), .SEL_W(SEL_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ins(Ins),
    .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .AluDone(AluDone),
    .Run(Run), .Rin(Rin), .Rout(Rout), .Yin(Yin), .SelectY(SelectY),
    .Zin(Zin), .Zout(Zout), .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
    .End(End), .Error(Error), .Step(Step)
  );

  assign obs = {Run, Rin, Rout, Yin, SelectY, Zin, Zout, Div, Mul, Sub, Add, End, Error, Step};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected output vector for a step (0 idle, 1..4 = T1..T4).
  function automatic logic [23:0] model(int ph, logic [3:0] ins, int a, int b, int d,
                                        bit zmd, bit err);
    logic       run, yin, sely, zin, zout, en;
    logic [3:0] rin, rout, ops;
    logic [4:0] st;
    run = (ph != 0);
    rin = '0; rout = '0; ops = '0;
    yin = 1'b0; sely = 1'b0; zin = 1'b0; zout = 1'b0; en = 1'b0;
    st = 5'b00001 << ph;
    case (ph)
      1: begin rout = 4'b0001 << a; yin = 1'b1; end
      2: begin
        rout = 4'b0001 << b; sely = 1'b1; ops = ins;
        zin = (ins[0] | ins[1]) ? 1'b1 : zmd;
      end
      3: begin zout = 1'b1; rin = 4'b0001 << d; end
      4: en = 1'b1;
      default: ;
    endcase
    return {run, rin, rout, yin, sely, zin, zout, ops, en, err, st};
  endfunction

  // Expected cycles of one accepted instruction; k = T2 cycle where AluDone rises, 0 = never.
  task automatic plan_txn(input logic [3:0] ins, input int a, input int b, input int d,
                          input int k);
    int n;
    bit multi;
    multi = ins[2] | ins[3];
    exp_q.push_back(model(1, ins, a, b, d, 1'b0, 1'b0)); ph_q.push_back(1);
    done_q.push_back(1'($urandom_range(0, 1)));
    if (!multi) begin
      exp_q.push_back(model(2, ins, a, b, d, 1'b0, 1'b0)); ph_q.push_back(2);
      done_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      n = (k == 0) ? MAX_WAIT + 1 : k;
      for (int i = 1; i <= n; i++) begin
        exp_q.push_back(model(2, ins, a, b, d, (i == k), 1'b0)); ph_q.push_back(2);
        done_q.push_back(i == k);
      end
    end
    if (multi && k == 0) begin
      exp_q.push_back(model(0, 4'b0, 0, 0, 0, 1'b0, 1'b1)); ph_q.push_back(0);
      done_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      exp_q.push_back(model(3, ins, a, b, d, 1'b0, 1'b0)); ph_q.push_back(3);
      done_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(model(4, ins, a, b, d, 1'b0, 1'b0)); ph_q.push_back(4);
      done_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic plan_idle();
    exp_q.push_back(model(0, 4'b0, 0, 0, 0, 1'b0, 1'b0)); ph_q.push_back(0);
    done_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic plan_reject();
    exp_q.push_back(model(0, 4'b0, 0, 0, 0, 1'b0, 1'b1)); ph_q.push_back(0);
    done_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Move to the next cycle's sample point, applying AluDone and ignorable noise.
  task automatic advance(output logic [23:0] e);
    int ph;
    @(posedge Clk); #1;
    ph = ph_q.pop_front();
    AluDone = done_q.pop_front();
    if (ph >= 1 && ph <= 3) begin
      Start = 1'($urandom_range(0, 1));
      Ins   = 4'($urandom);
      SrcA  = SEL_W'($urandom);
      SrcB  = SEL_W'($urandom);
      Dst   = SEL_W'($urandom);
    end else begin
      Start = 1'b0;
    end
    e = exp_q.pop_front();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Ins = 4'b0001; SrcA = 3'd1; SrcB = 3'd2; Dst = 3'd3;
    AluDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      checks++;
      if (obs !== model(0, 4'b0, 0, 0, 0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, obs,
                 model(0, 4'b0, 0, 0, 0, 1'b0, 1'b0));
      end
    end
    Reset = 1'b0; Start = 1'b0; AluDone = 1'b0;
  endtask

  task automatic test_add();
    logic [23:0] e;
    int c = 0;
    Start = 1'b1; Ins = 4'b0001; SrcA = 3'd1; SrcB = 3'd2; Dst = 3'd3;
    plan_txn(4'b0001, 1, 2, 3, 0);
    plan_idle();
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL add cyc%0d: got %h expected %h", c, obs, e); end
    end
  endtask

  task automatic test_mul_stall();
    logic [23:0] e;
    int c = 0;
    Start = 1'b1; Ins = 4'b0100; SrcA = 3'd3; SrcB = 3'd0; Dst = 3'd2;
    plan_txn(4'b0100, 3, 0, 2, 3);
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL mul_stall cyc%0d: got %h expected %h", c, obs, e); end
    end
  endtask

  task automatic test_div_timeout();
    logic [23:0] e;
    int c = 0;
    Start = 1'b1; Ins = 4'b1000; SrcA = 3'd0; SrcB = 3'd1; Dst = 3'd1;
    plan_txn(4'b1000, 0, 1, 1, 0);
    plan_idle();
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL div_timeout cyc%0d: got %h expected %h", c, obs, e); end
    end
  endtask

  task automatic test_reject();
    logic [23:0] e;
    logic [3:0] bad_ins [7] = '{4'b0011, 4'b0000, 4'b1111, 4'b0110, 4'b0001, 4'b0010, 4'b1000};
    logic [2:0] bad_a   [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd7, 3'd1};
    logic [2:0] bad_b   [7] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0, 3'd5};
    logic [2:0] bad_d   [7] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd2, 3'd3};
    for (int i = 0; i < 7; i++) begin
      Start = 1'b1; Ins = bad_ins[i]; SrcA = bad_a[i]; SrcB = bad_b[i]; Dst = bad_d[i];
      plan_reject();
      plan_idle();
      while (exp_q.size() != 0) begin
        advance(e); checks++;
        if (obs !== e) begin errors++; $display("FAIL reject case%0d: got %h expected %h", i, obs, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    int c = 0;
    Start = 1'b1; Ins = 4'b0001; SrcA = 3'd0; SrcB = 3'd1; Dst = 3'd2;
    plan_txn(4'b0001, 0, 1, 2, 0);
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b first cyc%0d: got %h expected %h", c, obs, e); end
    end
    Start = 1'b1; Ins = 4'b0010; SrcA = 3'd3; SrcB = 3'd2; Dst = 3'd0;
    plan_txn(4'b0010, 3, 2, 0, 0);
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b second cyc%0d: got %h expected %h", c, obs, e); end
    end
    Start = 1'b1; Ins = 4'b0000; SrcA = 3'd0; SrcB = 3'd0; Dst = 3'd0;
    plan_reject();
    plan_idle();
    while (exp_q.size() != 0) begin
      advance(e); c++; checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b reject cyc%0d: got %h expected %h", c, obs, e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] e;
    Start = 1'b1; Ins = 4'b0100; SrcA = 3'd2; SrcB = 3'd3; Dst = 3'd1;
    plan_txn(4'b0100, 2, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      advance(e); checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_reset pre cyc%0d: got %h expected %h", i, obs, e); end
    end
    exp_q.delete(); ph_q.delete(); done_q.delete();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0; AluDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (obs !== model(0, 4'b0, 0, 0, 0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL mid_reset post cyc%0d: got %h expected %h", i, obs,
                 model(0, 4'b0, 0, 0, 0, 1'b0, 1'b0));
      end
      if (i < 2) begin @(posedge Clk); #1; end
    end
    AluDone = 1'b0;
  endtask

  task automatic test_random();
    logic [23:0] e;
    logic [3:0]  ins;
    int r, a, b, d, k, sel;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        Start = 1'b0; Ins = 4'($urandom);
        SrcA = SEL_W'($urandom); SrcB = SEL_W'($urandom); Dst = SEL_W'($urandom);
        plan_idle();
      end else if (r == 1) begin
        Start = 1'b1; Ins = 4'(1 << $urandom_range(0, 3));
        SrcA = SEL_W'($urandom_range(0, 3)); SrcB = SEL_W'($urandom_range(0, 3));
        Dst = SEL_W'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
          do ins = 4'($urandom); while ($countones(ins) == 1);
          Ins = ins;
        end else begin
          sel = $urandom_range(0, 2);
          if (sel == 0) SrcA = SEL_W'($urandom_range(4, 7));
          else if (sel == 1) SrcB = SEL_W'($urandom_range(4, 7));
          else Dst = SEL_W'($urandom_range(4, 7));
        end
        plan_reject();
      end else begin
        ins = 4'(1 << $urandom_range(0, 3));
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); d = $urandom_range(0, 3);
        k = $urandom_range(0, MAX_WAIT + 1);
        Start = 1'b1; Ins = ins; SrcA = SEL_W'(a); SrcB = SEL_W'(b); Dst = SEL_W'(d);
        plan_txn(ins, a, b, d, k);
      end
      while (exp_q.size() != 0) begin
        advance(e); checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL random item%0d: got %h expected %h", t, obs, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_stall();
    test_div_timeout();
    test_reject();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
